// File: rtl/uart_echo.sv
// UART far-end loopback: 8N1 receiver -> small byte FIFO -> 8N1 transmitter at the same baud.
// Received bytes are echoed unchanged; TX may be held off with tx_enable while the queue fills.
module uart_echo #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          serial_rx,
  input  logic                          tx_enable,
  output logic                          serial_tx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FCW   = PTR_W + 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FCW-1:0]   FULL_CNT = FCW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic             rx_meta_q, rx_sync_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0]   count_q, count_d;
  logic             overflow_q;
  logic             push_s, pop_s, accept_s;

  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_busy_q;

  // Two-flop synchroniser on the asynchronous line input; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= serial_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver next state: half-bit start qualification, then centre sampling.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          // Return to idle at stop centre so the next start edge is not missed.
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // A push on a full queue is still accepted when TX pops in the same cycle.
  assign push_s   = rx_valid_q;
  assign accept_s = push_s && ((count_q != FULL_CNT) || pop_s);

  // Occupancy update for push/pop combinations.
  always_comb begin
    count_d = count_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + FCW'(1);
      2'b01:   count_d = count_q - FCW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept_s) begin
        mem_q[wr_ptr_q] <= rx_data_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_s && !accept_s) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Transmitter next state; the line value is computed here and registered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    pop_s      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (tx_enable && (count_q != '0)) begin
          pop_s      = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q];
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end else begin
          tx_cnt_d   = '0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  // Transmitter state registers; busy follows the next state so it aligns with the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= (tx_state_d != TX_IDLE);
    end
  end

  assign serial_tx  = tx_line_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign tx_busy    = tx_busy_q;

endmodule

// File: tb/tb_uart_echo.sv
// Bench for uart_echo: drives 8N1 frames, decodes serial_tx with a behavioural UART
// receiver and compares echoes against an ideal queue model of the echo path.
module tb_uart_echo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_rx = 1'b1;
  logic       tx_enable = 1'b1;
  logic       serial_tx;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overflow, tx_busy;
  logic [2:0] fifo_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rv_cnt = 0, fe_cnt = 0, rv_cyc = 0, tx_falls = 0, mon_bad = 0;
  logic [7:0] rv_last = 8'h00;
  logic prev_tx = 1'b1;
  logic [7:0] mon_q [$];
  int         mon_st_q [$];
  logic [7:0] exp_q [$];

  uart_echo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .serial_rx(serial_rx), .tx_enable(tx_enable),
    .serial_tx(serial_tx), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event trackers sampled mid-cycle
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rv_cnt  <= rv_cnt + 1;
      rv_cyc  <= cyc;
      rv_last <= rx_data;
    end
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (prev_tx === 1'b1 && serial_tx === 1'b0) tx_falls <= tx_falls + 1;
    prev_tx <= serial_tx;
  end

  // Behavioural UART receiver on serial_tx
  initial begin : tx_mon
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && serial_tx === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = serial_tx;
        end
        repeat (CPB) @(negedge clk);
        if (serial_tx !== 1'b1) mon_bad++;
        mon_q.push_back(b);
        mon_st_q.push_back(t0);
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    serial_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_b);
    serial_rx = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_q.delete();
    mon_st_q.delete();
    exp_q.delete();
  endtask

  // Wait for every expected byte to be echoed, then compare in order
  task automatic expect_echo(input string tag, input int budget);
    int n = exp_q.size();
    int k = 0;
    while (mon_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_count"}, mon_q.size(), n);
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      check({tag, "_byte"}, mon_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
  endtask

  initial begin : stim
    logic [7:0] b;
    int rv0, fe0, falls0, n;
    logic [7:0] seq2 [4];
    seq2[0] = 8'h00; seq2[1] = 8'hFF; seq2[2] = 8'h55; seq2[3] = 8'hA5;

    // Reset state
    #23;
    check("rst_serial_tx", serial_tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_fifo_count", fifo_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    // 1: single byte echo
    rv0 = rv_cnt;
    send_frame(8'hD5, 1'b1);
    exp_q.push_back(8'hD5);
    check("t1_rv_count", rv_cnt, rv0 + 1);
    check("t1_rx_data", rv_last, 8'hD5);
    expect_echo("t1_echo", 3 * FRAME);
    check("t1_latency_ok", (mon_st_q.size() == 1) && (mon_st_q[0] - rv_cyc >= 1)
          && (mon_st_q[0] - rv_cyc <= 2), 1);
    check("t1_count0", fifo_count, 0);
    check("t1_stop_bits", mon_bad, 0);
    mon_st_q.delete();

    // 2: back-to-back bytes, order preserved and 1-cycle gaps
    for (int i = 0; i < 4; i++) begin
      send_frame(seq2[i], 1'b1);
      exp_q.push_back(seq2[i]);
    end
    expect_echo("t2_echo", 4 * FRAME);
    for (int i = 0; i + 1 < mon_st_q.size(); i++)
      check("t2_gap", (mon_st_q[i + 1] - mon_st_q[i]) <= FRAME + 1, 1);
    check("t2_overflow", overflow, 0);
    mon_st_q.delete();

    // 3: hold TX, overflow the queue, then drain
    tx_enable = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      send_frame(8'(i), 1'b1);
      if (i <= DEPTH) exp_q.push_back(8'(i));
      check("t3_count", fifo_count, (i < DEPTH) ? i : DEPTH);
      check("t3_overflow", overflow, (i > DEPTH) ? 1 : 0);
    end
    tx_enable = 1'b1;
    expect_echo("t3_echo", 6 * FRAME);
    repeat (2 * FRAME) @(negedge clk);
    check("t3_no_extra", mon_q.size(), 0);
    check("t3_overflow_sticky", overflow, 1);
    check("t3_count0", fifo_count, 0);
    do_reset();

    // 4: bad stop bit
    rv0 = rv_cnt; fe0 = fe_cnt; falls0 = tx_falls;
    send_frame(8'h3C, 1'b0);
    repeat (2 * CPB) @(posedge clk); #1;
    check("t4_frame_err", fe_cnt, fe0 + 1);
    check("t4_no_rv", rv_cnt, rv0);
    check("t4_count", fifo_count, 0);
    check("t4_tx_idle", tx_falls, falls0);

    // 5: short glitch then a good byte
    rv0 = rv_cnt; fe0 = fe_cnt;
    serial_rx = 1'b0;
    repeat (4) @(posedge clk); #1;
    serial_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1;
    check("t5_glitch_rv", rv_cnt, rv0);
    check("t5_glitch_fe", fe_cnt, fe0);
    send_frame(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    check("t5_rx_data", rv_last, 8'h81);
    expect_echo("t5_echo", 3 * FRAME);

    // Randomised rounds: held TX with random burst length, then free-running stream
    for (int r = 0; r < 3; r++) begin
      do_reset();
      tx_enable = 1'b0;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1);
        if (k < DEPTH) exp_q.push_back(b);
      end
      check("rnd_count", fifo_count, (n < DEPTH) ? n : DEPTH);
      check("rnd_overflow", overflow, (n > DEPTH) ? 1 : 0);
      tx_enable = 1'b1;
      expect_echo("rnd_hold_echo", 6 * FRAME);
      n = $urandom_range(2, 6);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1);
        exp_q.push_back(b);
      end
      expect_echo("rnd_stream_echo", 4 * FRAME);
      check("rnd_count0", fifo_count, 0);
    end
    check("rnd_stop_bits", mon_bad, 0);

    // 6: reset during TX data with two bytes still queued
    do_reset();
    tx_enable = 1'b0;
    send_frame(8'hAA, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tx_enable = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1;
    check("t6_busy_before", tx_busy, 1);
    check("t6_count_before", fifo_count, 2);
    rst_n = 1'b0;
    #1;
    check("t6_tx_high", serial_tx, 1);
    check("t6_count0", fifo_count, 0);
    check("t6_busy0", tx_busy, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    falls0 = tx_falls;
    repeat (4 * FRAME) @(posedge clk); #1;
    check("t6_no_output", tx_falls, falls0);
    check("t6_line_idle", serial_tx, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
